// File: rtl/fpu_pkg.sv
// Shared FPU types and single-precision defaults used by the divider and its bus.
package fpu_pkg;

    localparam int          FP_EXP_W  = 8;
    localparam int          FP_FRAC_W = 23;
    localparam int          FP_BIAS   = 127;
    localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        ROUND,
        DONE
    } fdiv_state_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
    } fflags_t;

endpackage

// File: rtl/fdiv_seq_if.sv
// Operand/result handshake bundle between the FPU execute stage and the divider.
interface fdiv_seq_if #(
    parameter int EXP_W  = fpu_pkg::FP_EXP_W,
    parameter int FRAC_W = fpu_pkg::FP_FRAC_W
);
    import fpu_pkg::*;

    localparam int W = 1 + EXP_W + FRAC_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    fflags_t      flags;

    modport master (
        output in_valid, x1, x2, out_ready,
        input  in_ready, out_valid, y, flags
    );

    modport slave (
        input  in_valid, x1, x2, out_ready,
        output in_ready, out_valid, y, flags
    );

endinterface

// File: rtl/fdiv_step.sv
// One restoring-division step: conditional subtract of the divisor, then shift left.
module fdiv_step #(
    parameter int RW = 25
) (
    input  logic [RW-1:0] r,
    input  logic [RW-1:0] d,
    output logic [RW-1:0] r_next,
    output logic          q
);
    logic [RW-1:0] diff;

    always_comb begin
        q      = (r >= d);
        diff   = q ? (r - d) : r;
        r_next = diff << 1;
    end

endmodule

// File: rtl/fdiv_seq.sv
// Multi-cycle IEEE-754 divider: restoring mantissa division, STEPS quotient bits per clock,
// round-to-nearest-even, denormal flush on input and output.
module fdiv_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W,
    parameter int STEPS  = 2
) (
    input logic       clk,
    input logic       rst,
    fdiv_seq_if.slave bus
);
    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int QB    = FRAC_W + 3;
    localparam int ITERS = (QB + STEPS - 1) / STEPS;
    localparam int RW    = FRAC_W + 2;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int EW    = EXP_W + 2;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    function automatic logic rne_up(input logic g, input logic s, input logic lsb);
        return g & (s | lsb);
    endfunction

    fdiv_state_e       state, state_nx;
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              sgn;
    logic [EXP_W-1:0]  exp1, exp2;
    logic [RW-1:0]     rem, div;
    logic [QB-1:0]     quo;
    logic [W-1:0]      res_y;
    fflags_t           res_flags;

    logic              s1, s2, nan1, nan2, inf1, inf2, zero1, zero2, sgn_in;
    logic [EXP_W-1:0]  ex1, ex2;
    logic [FRAC_W-1:0] fr1, fr2;

    assign {s1, ex1, fr1} = bus.x1;
    assign {s2, ex2, fr2} = bus.x2;
    assign nan1   = (&ex1) & (|fr1);
    assign nan2   = (&ex2) & (|fr2);
    assign inf1   = (&ex1) & ~(|fr1);
    assign inf2   = (&ex2) & ~(|fr2);
    // A zero exponent covers denormals too, so they are treated as signed zero.
    assign zero1  = ~(|ex1);
    assign zero2  = ~(|ex2);
    assign sgn_in = s1 ^ s2;
    assign accept = bus.in_valid & (state == IDLE);

    logic         spec_hit;
    logic [W-1:0] spec_y;
    fflags_t      spec_flags;

    always_comb begin
        spec_hit   = 1'b1;
        spec_y     = QNAN;
        spec_flags = '0;
        if (nan1 | nan2) begin
            spec_y = QNAN;
        end else if ((zero1 & zero2) | (inf1 & inf2)) begin
            spec_flags.nv = 1'b1;
        end else if (zero2) begin
            spec_y        = {sgn_in, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            spec_flags.dz = 1'b1;
        end else if (inf1) begin
            spec_y = {sgn_in, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (zero1 | inf2) begin
            spec_y = {sgn_in, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Step chain; steps past QB in the final cycle pass R and Q through untouched.
    logic [RW-1:0] r_ch [STEPS+1];
    logic [QB-1:0] q_ch [STEPS+1];

    assign r_ch[0] = rem;
    assign q_ch[0] = quo;

    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
        logic [RW-1:0] r_nx;
        logic          qb;
        logic          en;

        fdiv_step #(.RW(RW)) u_step (
            .r      (r_ch[gi]),
            .d      (div),
            .r_next (r_nx),
            .q      (qb)
        );

        assign en           = (int'(cnt) * STEPS + gi) < QB;
        assign r_ch[gi + 1] = en ? r_nx : r_ch[gi];
        assign q_ch[gi + 1] = en ? {q_ch[gi][QB-2:0], qb} : q_ch[gi];
    end

    logic                 hi, g, st;
    logic [FRAC_W:0]      mant;
    logic [FRAC_W+1:0]    mant_r;
    logic [FRAC_W-1:0]    frac;
    logic signed [EW-1:0] e_pre, e_fin;
    logic [W-1:0]         rnd_y;
    fflags_t              rnd_flags;

    always_comb begin
        hi        = quo[QB-1];
        mant      = hi ? quo[QB-1:2] : quo[QB-2:1];
        g         = hi ? quo[1] : quo[0];
        st        = (hi & quo[0]) | (|rem);
        e_pre     = signed'({2'b00, exp1}) - signed'({2'b00, exp2}) + BIAS_S - (hi ? ZERO_S : ONE_S);
        mant_r    = {1'b0, mant} + {{(FRAC_W+1){1'b0}}, rne_up(g, st, mant[0])};
        frac      = mant_r[FRAC_W+1] ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];
        e_fin     = e_pre + (mant_r[FRAC_W+1] ? ONE_S : ZERO_S);
        rnd_y     = {sgn, e_fin[EXP_W-1:0], frac};
        rnd_flags = '0;
        if (e_fin >= EMAX_S) begin
            rnd_y        = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            rnd_flags.of = 1'b1;
        end else if (e_fin <= ZERO_S) begin
            rnd_y        = {sgn, {(W-1){1'b0}}};
            rnd_flags.uf = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = spec_hit ? DONE : ITER;
            ITER:    if (cnt == CW'(ITERS - 1)) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            res_y     <= '0;
            res_flags <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                cnt <= '0;
            else if (state == ITER)
                cnt <= cnt + CW'(1);
            if (accept && spec_hit) begin
                res_y     <= spec_y;
                res_flags <= spec_flags;
            end else if (state == ROUND) begin
                res_y     <= rnd_y;
                res_flags <= rnd_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sgn  <= sgn_in;
            exp1 <= ex1;
            exp2 <= ex2;
            rem  <= {1'b0, 1'b1, fr1};
            div  <= {1'b0, 1'b1, fr2};
            quo  <= '0;
        end else if (state == ITER) begin
            rem <= r_ch[STEPS];
            quo <= q_ch[STEPS];
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.y         = res_y;
    assign bus.flags     = res_flags;

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: vector table on STEPS=2 plus backpressure, reset and STEPS=1/4 latency.
module tb_fdiv_seq;
    import fpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fdiv_seq_if ifc1 ();
    fdiv_seq_if ifc2 ();
    fdiv_seq_if ifc4 ();

    // Index 0: STEPS=1, 1: STEPS=2, 2: STEPS=4
    logic        iv   [3];
    logic [31:0] xa   [3];
    logic [31:0] xb   [3];
    logic        ordy [3];
    logic        ov   [3];
    logic        ir   [3];
    logic [31:0] yy   [3];
    logic [3:0]  ff   [3];

    assign ifc1.in_valid = iv[0];  assign ifc1.x1 = xa[0];  assign ifc1.x2 = xb[0];  assign ifc1.out_ready = ordy[0];
    assign ifc2.in_valid = iv[1];  assign ifc2.x1 = xa[1];  assign ifc2.x2 = xb[1];  assign ifc2.out_ready = ordy[1];
    assign ifc4.in_valid = iv[2];  assign ifc4.x1 = xa[2];  assign ifc4.x2 = xb[2];  assign ifc4.out_ready = ordy[2];
    assign ov[0] = ifc1.out_valid; assign ir[0] = ifc1.in_ready; assign yy[0] = ifc1.y; assign ff[0] = ifc1.flags;
    assign ov[1] = ifc2.out_valid; assign ir[1] = ifc2.in_ready; assign yy[1] = ifc2.y; assign ff[1] = ifc2.flags;
    assign ov[2] = ifc4.out_valid; assign ir[2] = ifc4.in_ready; assign yy[2] = ifc4.y; assign ff[2] = ifc4.flags;

    fdiv_seq #(.STEPS(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));
    fdiv_seq #(.STEPS(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));
    fdiv_seq #(.STEPS(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4));

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // lat counts clock edges after the accept edge until out_valid is seen;
    // special cases are ready right after the accept edge (lat 0).
    task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] y, output logic [3:0] fl, output int lat);
        @(negedge clk);
        chk("in_ready_before_op", 32'(ir[s]), 32'd1);
        iv[s] = 1'b1; xa[s] = a; xb[s] = b; ordy[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
        lat = 0;
        while (!ov[s] && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov[s]) begin
            n_miss++;
            $display("FAIL timeout: out_valid low after %0d clocks, required high", lat);
        end
        y  = yy[s];
        fl = ff[s];
        @(posedge clk); #1;
    endtask

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t        tv [12];
    logic [31:0] ry;
    logic [3:0]  rf;
    int          rl;
    logic        seen;

    initial begin
        tv[0]  = '{"3.0/2.0",      32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 4'b0000, 14};
        tv[1]  = '{"1.0/3.0",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, 14};
        tv[2]  = '{"-1.0/3.0",     32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 4'b0000, 14};
        tv[3]  = '{"1.0/0",        32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 0};
        tv[4]  = '{"0/0",          32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 0};
        tv[5]  = '{"inf/inf",      32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, 0};
        tv[6]  = '{"qnan/1.0",     32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000, 0};
        tv[7]  = '{"2.0/inf",      32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 4'b0000, 0};
        tv[8]  = '{"max/0.25",     32'h7F7F_FFFF, 32'h3E80_0000, 32'h7F80_0000, 4'b0010, 14};
        tv[9]  = '{"minnorm/2",    32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 14};
        tv[10] = '{"-minnorm/2",   32'h8080_0000, 32'h4000_0000, 32'h8000_0000, 4'b0001, 14};
        tv[11] = '{"denorm/1.0",   32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 0};

        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; xa[i] = '0; xb[i] = '0; ordy[i] = 1'b1;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        chk("rst_out_valid", 32'(ov[1]), 32'd0);
        chk("rst_y", yy[1], 32'd0);
        chk("rst_flags", 32'(ff[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_s1", 32'(ir[0]), 32'd1);
        chk("rst_in_ready_s2", 32'(ir[1]), 32'd1);
        chk("rst_in_ready_s4", 32'(ir[2]), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_op(1, tv[i].a, tv[i].b, ry, rf, rl);
            n_vec++;
            chk({tv[i].nm, " y"}, ry, tv[i].y);
            chk({tv[i].nm, " flags"}, 32'(rf), 32'(tv[i].fl));
            chk({tv[i].nm, " latency"}, 32'(rl), 32'(tv[i].lat));
        end

        // Backpressure: result held while out_ready is low, in_valid pulses ignored
        n_vec++;
        @(negedge clk);
        iv[1] = 1'b1; xa[1] = 32'h4040_0000; xb[1] = 32'h4000_0000; ordy[1] = 1'b0;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        rl = 0;
        while (!ov[1] && rl < 60) begin
            @(posedge clk); #1;
            rl++;
        end
        chk("bp latency", 32'(rl), 32'd14);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv[1] = ~i[0]; xa[1] = 32'h3F80_0000; xb[1] = 32'h4040_0000;
            @(posedge clk); #1;
            chk("bp out_valid held", 32'(ov[1]), 32'd1);
            chk("bp y held", yy[1], 32'h3FC0_0000);
            chk("bp flags held", 32'(ff[1]), 32'd0);
            chk("bp in_ready low", 32'(ir[1]), 32'd0);
        end
        @(negedge clk);
        iv[1] = 1'b0; ordy[1] = 1'b1;
        @(posedge clk); #1;
        chk("bp release out_valid", 32'(ov[1]), 32'd0);
        chk("bp release in_ready", 32'(ir[1]), 32'd1);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            seen |= ov[1];
        end
        chk("bp no phantom op", 32'(seen), 32'd0);

        // Reset pulse in the middle of the iteration phase
        n_vec++;
        @(negedge clk);
        iv[1] = 1'b1; xa[1] = 32'h4040_0000; xb[1] = 32'h4000_0000;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("midrst in_ready", 32'(ir[1]), 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            seen |= ov[1];
        end
        chk("midrst out_valid stays low", 32'(seen), 32'd0);
        run_op(1, 32'h4040_0000, 32'h4000_0000, ry, rf, rl);
        n_vec++;
        chk("after rst y", ry, 32'h3FC0_0000);
        chk("after rst flags", 32'(rf), 32'd0);
        chk("after rst latency", 32'(rl), 32'd14);

        // Other STEPS values
        run_op(0, 32'h4040_0000, 32'h4000_0000, ry, rf, rl);
        n_vec++;
        chk("steps1 y", ry, 32'h3FC0_0000);
        chk("steps1 flags", 32'(rf), 32'd0);
        chk("steps1 latency", 32'(rl), 32'd27);
        run_op(2, 32'h4040_0000, 32'h4000_0000, ry, rf, rl);
        n_vec++;
        chk("steps4 y", ry, 32'h3FC0_0000);
        chk("steps4 flags", 32'(rf), 32'd0);
        chk("steps4 latency", 32'(rl), 32'd8);
        run_op(2, 32'h3F80_0000, 32'h4040_0000, ry, rf, rl);
        n_vec++;
        chk("steps4 1/3 y", ry, 32'h3EAA_AAAB);
        chk("steps4 1/3 latency", 32'(rl), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
